instr_mem_sync: RTL

INSTR_MEM_SYNC -- requirements
Module: instr_mem_sync

---
 rtl/imem_pkg.sv | 14 +
 rtl/imem_array.sv | 35 +++
 rtl/instr_mem_sync.sv | 98 +++++++++
 3 files changed

// File: rtl/imem_pkg.sv
// Shared defaults and the response bundle for the synchronous instruction memory.
package imem_pkg;

  localparam int unsigned IMEM_DATA_W = 32;
  localparam int unsigned IMEM_DEPTH  = 1024;
  localparam int unsigned IMEM_ADDR_W = 32;

  // One fetch result: fault flag plus the instruction word.
  typedef struct packed {
    logic                   fault;
    logic [IMEM_DATA_W-1:0] data;
  } imem_rsp_t;

endpackage

// File: rtl/imem_array.sv
// Word storage: one write port, one synchronous read port, read-before-write.
// The read register only updates on rd_en, so a response stays put while it waits.
module imem_array #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 1024,
  localparam int IDX_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rd_en,
  input  logic [IDX_W-1:0]  rd_idx,
  output logic [DATA_W-1:0] rd_data,
  input  logic              wr_en,
  input  logic [IDX_W-1:0]  wr_idx,
  input  logic [DATA_W-1:0] wr_data
);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] rd_data_d;
  logic [DATA_W-1:0] rd_data_q;

  // Next read word: capture on a read, otherwise hold the previous result.
  always_comb begin
    rd_data_d = rd_data_q;
    if (rd_en) rd_data_d = mem[rd_idx];
  end

  // Storage and read register; contents are never cleared, the read sees pre-write data.
  always_ff @(posedge clk) begin
    rd_data_q <= rd_data_d;
    if (wr_en) mem[wr_idx] <= wr_data;
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/instr_mem_sync.sv
// Synchronous instruction memory with a valid/ready fetch port and a load port.
// Optional feature: define IMEM_FAULT_CHECK_EN to flag misaligned or out-of-range
// fetches (rsp_fault=1, rsp_data=0); otherwise the address wraps modulo DEPTH.
module instr_mem_sync
  import imem_pkg::*;
#(
  parameter int DATA_W = IMEM_DATA_W,
  parameter int DEPTH  = IMEM_DEPTH,
  parameter int ADDR_W = IMEM_ADDR_W,
  localparam int IDX_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_fault,
  input  logic              ld_en,
  input  logic [IDX_W-1:0]  ld_idx,
  input  logic [DATA_W-1:0] ld_data
);

  logic              req_hs;
  logic [IDX_W-1:0]  req_idx;
  logic [DATA_W-1:0] rd_data;
  logic              rsp_valid_d;
  logic              rsp_valid_q;
  logic              fault_q;

  // Ready whenever the output slot is empty or being drained; reset always reports ready
  // but no handshake is taken while rst is high.
  assign req_ready = rst || !rsp_valid_q || rsp_ready;
  assign req_hs    = req_valid && req_ready && !rst;
  assign req_idx   = req_addr[IDX_W+1:2];

  imem_array #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_array (
    .clk     (clk),
    .rd_en   (req_hs),
    .rd_idx  (req_idx),
    .rd_data (rd_data),
    .wr_en   (ld_en),
    .wr_idx  (ld_idx),
    .wr_data (ld_data)
  );

  // Response slot occupancy: fill on handshake, drain when consumed, hold while stalled.
  always_comb begin
    rsp_valid_d = rsp_valid_q;
    if (req_hs)         rsp_valid_d = 1'b1;
    else if (rsp_ready) rsp_valid_d = 1'b0;
  end

  // Response valid register; reset discards any pending response.
  always_ff @(posedge clk) begin
    if (rst) rsp_valid_q <= 1'b0;
    else     rsp_valid_q <= rsp_valid_d;
  end

`ifdef IMEM_FAULT_CHECK_EN
  logic fault_d;

  // Misaligned, or any address bit beyond the last word index set.
  function automatic logic addr_fault(input logic [ADDR_W-1:0] a);
    logic f;
    f = |a[1:0];
    for (int i = IDX_W + 2; i < ADDR_W; i++) f = f | a[i];
    return f;
  endfunction

  // Fault flag travels with the fetch it belongs to.
  always_comb begin
    fault_d = fault_q;
    if (req_hs) fault_d = addr_fault(req_addr);
  end

  // Fault register, cleared by reset.
  always_ff @(posedge clk) begin
    if (rst) fault_q <= 1'b0;
    else     fault_q <= fault_d;
  end
`else
  logic unused_addr_bits;
  assign unused_addr_bits = ^{req_addr[1:0], req_addr[ADDR_W-1:IDX_W+2]};
  assign fault_q          = 1'b0;
`endif

  // Data is zero when no response is held (including after reset) or when faulted.
  assign rsp_valid = rsp_valid_q;
  assign rsp_fault = fault_q;
  assign rsp_data  = (rsp_valid_q && !fault_q) ? rd_data : '0;

endmodule
